// File: rtl/c7bexu_ecl_pkg.sv
// Shared constants and helpers for the EXU stall path.
// Counter widths are derived from maximum counts.
package c7bexu_ecl_pkg;

  localparam int C7B_LSU_MAX_OUTST = 2;
  localparam int C7B_CSR_STALL_CYC = 2;

  // Bits needed to hold 0..v, never less than one.
  function automatic int c7b_cnt_w(input int v);
    int w;
    w = $clog2(v + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/c7bexu_ecl_cnt.sv
// Saturating up/down counter: one increment, up to two decrements,
// synchronous load; flags a decrement below zero.
import c7bexu_ecl_pkg::*;

module c7bexu_ecl_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic [1:0]   dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic         underflow
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W+1:0] up_s;
  logic [W+1:0] dn_s;
  logic [W+1:0] diff_s;

  always_comb begin
    up_s      = {2'b00, cnt_q} + (W+2)'(inc);
    dn_s      = (W+2)'(dec[0]) + (W+2)'(dec[1]);
    diff_s    = up_s - dn_s;
    cnt_d     = diff_s[W-1:0];
    underflow = 1'b0;
    if (load) begin
      cnt_d = load_val;
    end else if (dn_s > up_s) begin
      cnt_d     = '0;
      underflow = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/c7bexu_ecl_stall.sv
// EXU stall control: LSU occupancy tracking, CSR serialisation
// window, IFU/M-stage stall lines and exception pulse.
import c7bexu_ecl_pkg::*;

module c7bexu_ecl_stall #(
  parameter int LSU_MAX_OUTST = C7B_LSU_MAX_OUTST,
  parameter int CNT_W         = c7b_cnt_w(LSU_MAX_OUTST),
  parameter int CSR_STALL_CYC = C7B_CSR_STALL_CYC,
  parameter int CSR_CNT_W     = c7b_cnt_w(CSR_STALL_CYC),
  parameter int LSU_BLOCKING  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lsu_vld_e,
  input  logic             lsu_except_ale_ls1,
  input  logic             lsu_except_buserr_ls3,
  input  logic             lsu_except_ecc_ls3,
  input  logic             lsu_data_valid_ls3,
  input  logic             lsu_wr_fin_ls3,
  input  logic             csr_vld_e,
  output logic             stall_ifu,
  output logic             stall_m,
  output logic             lsu_accept_e,
  output logic [CNT_W-1:0] lsu_outst,
  output logic             lsu_except,
  output logic             err_underflow
);

  logic                 full;
  logic                 ret1;
  logic                 ret3;
  logic                 lsu_uf;
  logic                 csr_uf;
  logic [CSR_CNT_W-1:0] csr_cnt;
  logic                 csr_busy;
  logic                 lsu_busy;
  logic                 exc_q;
  logic                 exc_d;
  logic                 err_q;
  logic                 err_d;

  assign full = (lsu_outst == CNT_W'(LSU_MAX_OUTST));
  assign ret1 = lsu_except_ale_ls1;
  assign ret3 = lsu_except_buserr_ls3 | lsu_except_ecc_ls3
              | lsu_data_valid_ls3 | lsu_wr_fin_ls3;

  assign lsu_accept_e = lsu_vld_e & ~full;
  assign stall_m      = lsu_vld_e & full;

  c7bexu_ecl_cnt #(.W(CNT_W)) u_lsu_cnt (
    .clk       (clk),
    .rst       (reset),
    .inc       (lsu_accept_e),
    .dec       ({ret3, ret1}),
    .load      (1'b0),
    .load_val  ({CNT_W{1'b0}}),
    .q         (lsu_outst),
    .underflow (lsu_uf)
  );

  assign csr_busy = (csr_cnt != '0);

  // Window counter only counts down while open, so it never underflows.
  c7bexu_ecl_cnt #(.W(CSR_CNT_W)) u_csr_cnt (
    .clk       (clk),
    .rst       (reset),
    .inc       (1'b0),
    .dec       ({1'b0, csr_busy}),
    .load      (csr_vld_e),
    .load_val  (CSR_CNT_W'(CSR_STALL_CYC)),
    .q         (csr_cnt),
    .underflow (csr_uf)
  );

  assign lsu_busy  = (LSU_BLOCKING != 0) ? (lsu_outst != '0) : full;
  assign stall_ifu = csr_busy | lsu_busy;

  always_comb begin
    exc_d = lsu_except_ale_ls1 | lsu_except_buserr_ls3
          | lsu_except_ecc_ls3;
    err_d = err_q | lsu_uf | csr_uf;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      exc_q <= exc_d;
      err_q <= err_d;
    end
  end

  assign lsu_except    = exc_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_c7bexu_ecl_stall.sv
// Directed bench for the EXU stall path with a per-cycle reference
// model; covers blocking and non-blocking LSU stall modes.
module tb_c7bexu_ecl_stall;

  localparam int MAXO = 2;
  localparam int CSRC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic vld = 0, ale = 0, bus = 0, ecc = 0, dv = 0, wf = 0, csr = 0;

  logic       b_sifu, b_sm, b_acc, b_exc, b_err;
  logic [1:0] b_out;
  logic       n_sifu, n_sm, n_acc, n_exc, n_err;
  logic [1:0] n_out;

  int vecs = 0;
  int miss = 0;

  int m_outst = 0;
  int m_csr   = 0;
  int m_exc   = 0;
  int m_err   = 0;

  always #5 clk = ~clk;

  c7bexu_ecl_stall dut (
    .clk(clk), .reset(reset), .lsu_vld_e(vld),
    .lsu_except_ale_ls1(ale), .lsu_except_buserr_ls3(bus),
    .lsu_except_ecc_ls3(ecc), .lsu_data_valid_ls3(dv),
    .lsu_wr_fin_ls3(wf), .csr_vld_e(csr),
    .stall_ifu(b_sifu), .stall_m(b_sm), .lsu_accept_e(b_acc),
    .lsu_outst(b_out), .lsu_except(b_exc), .err_underflow(b_err)
  );

  c7bexu_ecl_stall #(.LSU_BLOCKING(0)) dut_nb (
    .clk(clk), .reset(reset), .lsu_vld_e(vld),
    .lsu_except_ale_ls1(ale), .lsu_except_buserr_ls3(bus),
    .lsu_except_ecc_ls3(ecc), .lsu_data_valid_ls3(dv),
    .lsu_wr_fin_ls3(wf), .csr_vld_e(csr),
    .stall_ifu(n_sifu), .stall_m(n_sm), .lsu_accept_e(n_acc),
    .lsu_outst(n_out), .lsu_except(n_exc), .err_underflow(n_err)
  );

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               nm, $time, act, exp);
    end
  endtask

  // Reference model: occupancy as an integer, CSR window as cycles left.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_outst = 0;
      m_csr   = 0;
      m_exc   = 0;
      m_err   = 0;
    end else begin
      int acc, rets, nxt;
      acc  = (vld && m_outst < MAXO) ? 1 : 0;
      rets = (ale ? 1 : 0) + ((bus || ecc || dv || wf) ? 1 : 0);
      nxt  = m_outst + acc - rets;
      if (nxt < 0) begin
        nxt   = 0;
        m_err = 1;
      end
      m_outst = nxt;
      if (csr)            m_csr = CSRC;
      else if (m_csr > 0) m_csr = m_csr - 1;
      m_exc = (ale || bus || ecc) ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    int full_m, acc_m;
    full_m = (m_outst == MAXO) ? 1 : 0;
    acc_m  = (vld && !full_m) ? 1 : 0;
    chk("b_outst", int'(b_out), m_outst);
    chk("b_accept", int'(b_acc), acc_m);
    chk("b_stall_m", int'(b_sm), (vld && full_m) ? 1 : 0);
    chk("b_stall_ifu", int'(b_sifu),
        (m_csr != 0 || m_outst != 0) ? 1 : 0);
    chk("b_except", int'(b_exc), m_exc);
    chk("b_err", int'(b_err), m_err);
    chk("n_outst", int'(n_out), m_outst);
    chk("n_accept", int'(n_acc), acc_m);
    chk("n_stall_ifu", int'(n_sifu),
        (m_csr != 0 || full_m != 0) ? 1 : 0);
    chk("n_err", int'(n_err), m_err);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;

    // idle after reset
    chk("lit_idle_outst", int'(b_out), 0);
    chk("lit_idle_sifu", int'(b_sifu), 0);
    chk("lit_idle_sm", int'(b_sm), 0);
    repeat (5) step();

    // CSR window of two cycles
    csr = 1; step(); csr = 0;
    chk("lit_csr_w0", int'(b_sifu), 1);
    step();
    chk("lit_csr_w1", int'(b_sifu), 1);
    step();
    chk("lit_csr_end", int'(b_sifu), 0);

    // CSR window restart
    csr = 1; step(); csr = 0;
    step();
    csr = 1; step(); csr = 0;
    chk("lit_csr_re0", int'(b_sifu), 1);
    step();
    chk("lit_csr_re1", int'(b_sifu), 1);
    step();
    chk("lit_csr_re2", int'(b_sifu), 0);

    // issue then load return
    vld = 1; step(); vld = 0;
    chk("lit_ld_outst1", int'(b_out), 1);
    chk("lit_ld_sifu1", int'(b_sifu), 1);
    dv = 1; step(); dv = 0;
    chk("lit_ld_outst0", int'(b_out), 0);
    chk("lit_ld_sifu0", int'(b_sifu), 0);
    chk("lit_ld_exc", int'(b_exc), 0);

    // issue then misaligned exception
    vld = 1; step(); vld = 0;
    ale = 1; step(); ale = 0;
    chk("lit_ale_outst", int'(b_out), 0);
    chk("lit_ale_sifu", int'(b_sifu), 0);
    chk("lit_ale_exc1", int'(b_exc), 1);
    step();
    chk("lit_ale_exc0", int'(b_exc), 0);

    // fill to max, back-pressure, double retire
    vld = 1; #1;
    chk("lit_fill_acc0", int'(b_acc), 1);
    step();
    chk("lit_fill_acc1", int'(b_acc), 1);
    step();
    chk("lit_fill_acc2", int'(b_acc), 0);
    chk("lit_fill_sm", int'(b_sm), 1);
    chk("lit_fill_outst", int'(b_out), 2);
    step(); vld = 0;
    wf = 1; ale = 1; step(); wf = 0; ale = 0;
    chk("lit_dbl_ret", int'(b_out), 0);

    // non-blocking mode thresholds
    vld = 1; step(); vld = 0;
    chk("lit_nb_one", int'(n_sifu), 0);
    chk("lit_b_one", int'(b_sifu), 1);
    vld = 1; step(); vld = 0;
    chk("lit_nb_two", int'(n_sifu), 1);
    wf = 1; ecc = 1; bus = 1; ale = 1; step();
    wf = 0; ecc = 0; bus = 0; ale = 0;
    chk("lit_multi_ls3", int'(b_out), 0);

    // underflow is sticky
    dv = 1; step(); dv = 0;
    chk("lit_uf_set", int'(b_err), 1);
    repeat (3) step();
    chk("lit_uf_hold", int'(n_err), 1);

    // async reset mid-operation
    vld = 1; step(); step(); vld = 0;
    csr = 1; step(); csr = 0;
    #3 reset = 1'b1;
    #1;
    chk("lit_rst_outst", int'(b_out), 0);
    chk("lit_rst_sifu", int'(b_sifu), 0);
    chk("lit_rst_sm", int'(b_sm), 0);
    chk("lit_rst_exc", int'(b_exc), 0);
    chk("lit_rst_err", int'(b_err), 0);
    chk("lit_rst_nb_sifu", int'(n_sifu), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/c7bexu_ecl_stall.md
Name: c7bexu_ecl_stall

Overview:
Parametrised successor to the execution control logic stall path. It tracks up to LSU_MAX_OUTST in-flight LSU operations with an up/down occupancy counter. A CSR serialisation window has a configurable length. The block supports blocking and non-blocking LSU stall modes and back-pressures the M stage when the LSU queue is full. It sits in the EXU between decode/issue (E stage) and the LSU pipeline (ls1..ls3), and drives the IFU and M-stage stall lines.

Parameters:
LSU_MAX_OUTST, 2, max in-flight LSU ops (>=1)
CNT_W, $clog2(LSU_MAX_OUTST+1), occupancy counter width
CSR_STALL_CYC, 2, IFU stall cycles after a CSR op (0 = none)
CSR_CNT_W, $clog2(CSR_STALL_CYC+1) (min 1), CSR window counter width
LSU_BLOCKING, 1, 1: stall IFU while any LSU op is outstanding; 0: stall only when the counter is full

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  asynchronous, active-high reset
lsu_vld_e  in  1  LSU op requests issue in E
lsu_except_ale_ls1  in  1  misaligned-address exception; retires one op (ls1 retire)
lsu_except_buserr_ls3  in  1  bus error; ls3 retire
lsu_except_ecc_ls3  in  1  ECC error; ls3 retire
lsu_data_valid_ls3  in  1  load data returned; ls3 retire
lsu_wr_fin_ls3  in  1  store finished; ls3 retire
csr_vld_e  in  1  CSR op in E
stall_ifu  out  1  freeze fetch
stall_m  out  1  hold M stage / refuse LSU issue this cycle
lsu_accept_e  out  1  LSU op accepted this cycle
lsu_outst  out  CNT_W  current occupancy
lsu_except  out  1  registered one-cycle exception pulse
err_underflow  out  1  sticky: retire seen with empty counter

Behaviour:
- Reset (async, active-high): lsu_outst=0, CSR counter=0, lsu_except=0, err_underflow=0. Therefore stall_ifu=0, stall_m=0 and lsu_accept_e=0 (with lsu_vld_e=0). Reset asserted mid-operation drops all outstanding ops and any CSR window immediately.
- full = (lsu_outst == LSU_MAX_OUTST).
- lsu_accept_e = lsu_vld_e & ~full (combinational). stall_m = lsu_vld_e & full (combinational). Retires in the same cycle do not free a slot for that cycle's issue.
- ret1 = lsu_except_ale_ls1.
- ret3 = OR of buserr_ls3, ecc_ls3, data_valid_ls3 and wr_fin_ls3. Several ls3 signals asserted together count as one retire.
- Up to 2 retires per cycle.
- Next count = lsu_outst + accept − ret1 − ret3, saturating at 0.
- If the requested decrement exceeds lsu_outst + accept, the count clamps to 0 and err_underflow sets. err_underflow stays set until reset.
- CSR counter:
  - csr_vld_e loads CSR_STALL_CYC; otherwise the counter decrements toward 0.
  - csr_vld_e while the counter is nonzero reloads it, extending the window.
  - With CSR_STALL_CYC=0 the counter stays at 0.
- stall_ifu = (csr_cnt != 0) | (LSU_BLOCKING ? lsu_outst != 0 : full).
  - Derived from registered state only, so it rises the cycle after the triggering E-stage event.
- lsu_except is registered: 1 for exactly one cycle after any cycle with ale_ls1 | buserr_ls3 | ecc_ls3.
- csr_vld_e and lsu_vld_e in the same cycle are both processed independently.
- An issue and a retire in the same cycle leave the count unchanged (+1 −1).

Decomposition:
- Package c7bexu_ecl_pkg holds:
  - default constants C7B_LSU_MAX_OUTST=2 and C7B_CSR_STALL_CYC=2;
  - a localparam function for counter width, clog2 with minimum 1.
- One sub-module, c7bexu_ecl_cnt: a parametrised saturating up/down counter (width W, inc, dec[1:0], load, load_val, underflow flag).
  - Instantiated twice: LSU occupancy and CSR window.
  - The top level adds the stall/accept logic and the exception pulse register.

Test Plan:
- Idle after reset (defaults) → stall_ifu=0, stall_m=0, lsu_outst=0 for 5 cycles.
- csr_vld_e pulse for 1 cycle → stall_ifu=1 for exactly 2 cycles starting the next cycle, then 0. Second csr_vld_e during the window → window restarts at 2.
- lsu_vld_e 1 cycle, then lsu_data_valid_ls3 1 cycle → lsu_outst 1 then 0, stall_ifu 1 then 0, lsu_except never 1.
- lsu_vld_e 1 cycle, then lsu_except_ale_ls1 → lsu_outst=0 and stall_ifu=0 after that edge, lsu_except=1 for one cycle.
- lsu_vld_e held 3 cycles (MAX=2) → lsu_accept_e 1,1,0; stall_m=1 on the 3rd cycle; lsu_outst=2. Then lsu_wr_fin_ls3 together with lsu_except_ale_ls1 → lsu_outst=0.
- LSU_BLOCKING=0, MAX=2: one op outstanding → stall_ifu=0; two ops → stall_ifu=1. Retire with lsu_outst=0 → err_underflow=1 and stays 1. Reset asserted mid-operation → all outputs 0 immediately.
